// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//
// Shares the single physical-memory port (256-bit cacheline bus) between
// the instruction cache and the data cache. One cache owns the port at a
// time. It keeps ownership until memory answers, and the answer is routed
// back to that cache only. When both caches want the port, ownership
// alternates so that neither can starve the other.
//
// Ports
//   clk, rst                    clock and asynchronous active-high reset
//   i_pmem_*                    icache line-fill side (read only)
//   d_pmem_*                    dcache line-fill / write-back side
//   pmem_*                      memory / L2 side
//
// Read data is broadcast to both caches at all times. Only the per-cache
// resp strobe says whose data it is.
module cacheline_arbiter #(
    parameter int s_addr = 32,
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [s_addr-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [s_addr-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [s_addr-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // State register. last_d_q records whether the most recent completed
    // grant went to the dcache. Reset clears it, so the first contended
    // grant goes to the dcache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Next-state and output logic. Every memory-side output defaults to
    // zero. The owner's request lines are forwarded combinationally only
    // while a grant is held. The RELEASE state sits between a response and
    // the next arbitration. It gives the finished cache one cycle to drop
    // its request, so that request is not mistaken for a new one.
    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = pmem_rdata;
        d_pmem_rdata = pmem_rdata;

        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = last_d_q ? GRANT_I : GRANT_D;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end else if (i_req) begin
                    state_d = GRANT_I;
                end
            end

            GRANT_I: begin
                pmem_address = i_pmem_address;
                pmem_read    = i_pmem_read;
                i_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    state_d  = RELEASE;
                    last_d_d = 1'b0;
                end
            end

            GRANT_D: begin
                pmem_address = d_pmem_address;
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    state_d  = RELEASE;
                    last_d_d = 1'b1;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
